cpu_run_ctrl: RTL and testbench

Run/step/breakpoint sequencer for the pipelined MIPS debug platform. It replaces the raw run-mode clock mux in front of the CPU with a single-clock-domain controller. It debounces the step button, paces free-running execution with a divider, optionally halts on a PC breakpoint, and emits a one-cycle `cpu_en` qualifier that the CPU pipeline registers use as a clock enable. It also exports state and an executed-cycle count for the VGA debug display.

---
 rtl/cpu_ctrl_pkg.sv | 16 +
 rtl/btn_debounce.sv | 63 ++++++
 rtl/cpu_run_ctrl.sv | 151 +++++++++++++++
 tb/tb_cpu_run_ctrl.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg
//   Shared definitions for the CPU run/step/breakpoint sequencer:
//   state encodings, parameter defaults and the executed-cycle counter width.
package cpu_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_STEP = 2'd0,
      ST_RUN  = 2'd1,
      ST_HALT = 2'd2
   } state_t;

   localparam int DB_CYCLES_DEF = 16;
   localparam int RUN_DIV_DEF   = 4;
   localparam int CNT_W         = 16;

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce
//   Two-flop synchronizer, stability counter and rising-edge detector for a
//   raw push button. The debounced level flips only after DB_CYCLES
//   consecutive synchronized samples that differ from it.
// Ports:
//   clk      in   system clock
//   reset_n  in   asynchronous active-low reset
//   btn      in   raw button, asynchronous to clk
//   press    out  one-cycle pulse on the debounced rising edge (registered)
module btn_debounce
   import cpu_ctrl_pkg::*;
#(
   parameter int DB_CYCLES = DB_CYCLES_DEF
) (
   input  logic clk,
   input  logic reset_n,
   input  logic btn,
   output logic press
);

   localparam int DB_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

   logic            sync1_q, sync2_q;
   logic            level_q, level_d;
   logic            level_dly_q;
   logic            press_q, press_d;
   logic [DB_W-1:0] stab_q, stab_d;

   always_comb begin
      level_d = level_q;
      stab_d  = '0;
      // Any sample matching the current level restarts the count.
      if (sync2_q != level_q) begin
         if (stab_q == DB_W'(DB_CYCLES - 1)) begin
            level_d = sync2_q;
         end else begin
            stab_d = stab_q + 1'b1;
         end
      end
      press_d = level_q & ~level_dly_q;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1_q     <= 1'b0;
         sync2_q     <= 1'b0;
         level_q     <= 1'b0;
         level_dly_q <= 1'b0;
         press_q     <= 1'b0;
         stab_q      <= '0;
      end else begin
         sync1_q     <= btn;
         sync2_q     <= sync1_q;
         level_q     <= level_d;
         level_dly_q <= level_q;
         press_q     <= press_d;
         stab_q      <= stab_d;
      end
   end

   assign press = press_q;

endmodule

// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl
//   Run/step/breakpoint sequencer producing a one-cycle cpu_en pipeline
//   advance qualifier. Single step on a debounced button press, paced
//   free-run through a divider, optional halt on a PC breakpoint.
//   Optional feature macro: CPU_BREAKPOINT_EN (breakpoint comparator, skip
//   flag and HALT state). Without it bp_addr/bp_valid are ignored, HALT is
//   unreachable and halted is tied low.
// Ports:
//   clk        in   system clock
//   reset_n    in   asynchronous active-low reset
//   step       in   raw step button
//   run_mode   in   1 = free run, 0 = single step
//   pc         in   current CPU PC
//   bp_addr    in   breakpoint address
//   bp_valid   in   breakpoint armed
//   cpu_en     out  one-cycle pipeline advance enable
//   halted     out  high in HALT
//   state      out  0 = STEP, 1 = RUN, 2 = HALT
//   cycle_cnt  out  number of cpu_en pulses issued (wraps)
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_STEP | idle; each press issues one cpu_en
// ST_RUN  | free run; cpu_en every RUN_DIV cycles unless breakpoint hits
// ST_HALT | stopped on breakpoint; press resumes (run) or single-steps
module cpu_run_ctrl
   import cpu_ctrl_pkg::*;
#(
   parameter int DB_CYCLES = DB_CYCLES_DEF,
   parameter int RUN_DIV   = RUN_DIV_DEF
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             step,
   input  logic             run_mode,
   input  logic [31:0]      pc,
   input  logic [31:0]      bp_addr,
   input  logic             bp_valid,
   output logic             cpu_en,
   output logic             halted,
   output logic [1:0]       state,
   output logic [CNT_W-1:0] cycle_cnt
);

   localparam int DIV_W = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;

   state_t             state_q, state_d;
   logic [DIV_W-1:0]   div_q, div_d;
   logic               skip_q, skip_d;
   logic               cpu_en_q, cpu_en_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               press;
   logic               bp_hit;

   btn_debounce #(
      .DB_CYCLES(DB_CYCLES)
   ) u_btn (
      .clk    (clk),
      .reset_n(reset_n),
      .btn    (step),
      .press  (press)
   );

`ifdef CPU_BREAKPOINT_EN
   assign bp_hit = bp_valid && (pc == bp_addr) && !skip_q;
   assign halted = (state_q == ST_HALT);
`else
   logic unused_bp;
   assign unused_bp = ^{pc, bp_addr, bp_valid, skip_q};
   assign bp_hit    = 1'b0;
   assign halted    = 1'b0;
`endif

   always_comb begin
      state_d  = state_q;
      div_d    = div_q;
      skip_d   = skip_q;
      cpu_en_d = 1'b0;
      cnt_d    = cnt_q;

      case (state_q)
         ST_STEP: begin
            // Entering run wins over a coincident press.
            if (run_mode) begin
               state_d = ST_RUN;
               div_d   = '0;
            end else if (press) begin
               cpu_en_d = 1'b1;
            end
         end
         ST_RUN: begin
            if (!run_mode) begin
               state_d = ST_STEP;
               div_d   = '0;
            end else if (div_q == DIV_W'(RUN_DIV - 1)) begin
               div_d = '0;
               if (bp_hit) begin
                  state_d = ST_HALT;
               end else begin
                  cpu_en_d = 1'b1;
               end
            end else begin
               div_d = div_q + 1'b1;
            end
         end
         ST_HALT: begin
            if (press) begin
               if (run_mode) begin
                  // Skip lets the instruction parked on the breakpoint issue.
                  state_d = ST_RUN;
                  div_d   = '0;
                  skip_d  = 1'b1;
               end else begin
                  state_d  = ST_STEP;
                  cpu_en_d = 1'b1;
               end
            end
         end
         default: begin
            state_d = ST_STEP;
            div_d   = '0;
         end
      endcase

      if (cpu_en_d) begin
         skip_d = 1'b0;
         cnt_d  = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= ST_STEP;
         div_q    <= '0;
         skip_q   <= 1'b0;
         cpu_en_q <= 1'b0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         div_q    <= div_d;
         skip_q   <= skip_d;
         cpu_en_q <= cpu_en_d;
         cnt_q    <= cnt_d;
      end
   end

   assign cpu_en    = cpu_en_q;
   assign state     = state_q;
   assign cycle_cnt = cnt_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed testbench for cpu_run_ctrl. Main instance uses DB_CYCLES=16,
// RUN_DIV=4; a second instance with RUN_DIV=1 exercises the counter wrap.
module tb_cpu_run_ctrl;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        step, run_mode, bp_valid;
   logic [31:0] pc, bp_addr;
   logic        cpu_en, halted;
   logic [1:0]  state;
   logic [15:0] cycle_cnt;

   logic        step_w, run_mode_w;
   logic        cpu_en_w, halted_w;
   logic [1:0]  state_w;
   logic [15:0] cycle_cnt_w;
   logic [31:0] zero32 = 32'd0;
   logic        zero1  = 1'b0;

   int          n_cmp = 0;
   int          n_err = 0;
   int          en_seen = 0;
   logic [31:0] last_pc = 32'd0;
   bit          pc_inc = 1'b1;

   always #5 clk = ~clk;

   cpu_run_ctrl #(.DB_CYCLES(16), .RUN_DIV(4)) dut (
      .clk(clk), .reset_n(reset_n), .step(step), .run_mode(run_mode),
      .pc(pc), .bp_addr(bp_addr), .bp_valid(bp_valid),
      .cpu_en(cpu_en), .halted(halted), .state(state), .cycle_cnt(cycle_cnt)
   );

   cpu_run_ctrl #(.DB_CYCLES(2), .RUN_DIV(1)) dut_w (
      .clk(clk), .reset_n(reset_n), .step(step_w), .run_mode(run_mode_w),
      .pc(zero32), .bp_addr(zero32), .bp_valid(zero1),
      .cpu_en(cpu_en_w), .halted(halted_w), .state(state_w), .cycle_cnt(cycle_cnt_w)
   );

   // Advance one clock, sample just after the edge, model the CPU PC advance.
   task automatic tick;
      @(posedge clk);
      #1;
      if (cpu_en === 1'b1) begin
         en_seen++;
         last_pc = pc;
         if (pc_inc) pc = pc + 32'd4;
      end
   endtask

   task automatic test_reset;
      reset_n = 1'b0; step = 1'b0; run_mode = 1'b0; pc = 32'd0;
      bp_addr = 32'd0; bp_valid = 1'b0; step_w = 1'b0; run_mode_w = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_cmp++; if (cpu_en !== 1'b0) begin n_err++; $display("FAIL rst_cpu_en: got %b want 0", cpu_en); end
      n_cmp++; if (halted !== 1'b0) begin n_err++; $display("FAIL rst_halted: got %b want 0", halted); end
      n_cmp++; if (state !== 2'd0) begin n_err++; $display("FAIL rst_state: got %0d want 0", state); end
      n_cmp++; if (cycle_cnt !== 16'd0) begin n_err++; $display("FAIL rst_cycle_cnt: got %0h want 0", cycle_cnt); end
      reset_n = 1'b1;
      tick; tick;
      n_cmp++; if (state !== 2'd0 || cpu_en !== 1'b0) begin n_err++; $display("FAIL post_rst_idle: state %0d en %b want 0 0", state, cpu_en); end
   endtask

   task automatic test_debounce;
      int start;
      int first;
      start = en_seen;
      for (int b = 0; b < 3; b++) begin
         step = 1'b1; repeat (5) tick;
         step = 1'b0; repeat (5) tick;
      end
      n_cmp++; if (en_seen - start !== 0) begin n_err++; $display("FAIL bounce_pulses: got %0d want 0", en_seen - start); end
      step = 1'b1;
      first = 0;
      for (int i = 1; i <= 40; i++) begin
         tick;
         if (cpu_en === 1'b1 && first == 0) first = i;
      end
      n_cmp++; if (en_seen - start !== 1) begin n_err++; $display("FAIL press_pulses: got %0d want 1", en_seen - start); end
      n_cmp++; if (first !== 20) begin n_err++; $display("FAIL press_latency: got %0d want 20", first); end
      n_cmp++; if (cycle_cnt !== 16'd1) begin n_err++; $display("FAIL press_cycle_cnt: got %0d want 1", cycle_cnt); end
      step = 1'b0;
      repeat (25) tick;
      n_cmp++; if (en_seen - start !== 1) begin n_err++; $display("FAIL release_pulses: got %0d want 1", en_seen - start); end
   endtask

   task automatic test_run_pacing;
      int start, first, prev, gap_err;
      start = en_seen; first = 0; prev = 0; gap_err = 0;
      run_mode = 1'b1;
      for (int i = 1; i <= 101; i++) begin
         tick;
         if (i == 82) step = 1'b1;  // press lands in the cycle run_mode drops
         if (cpu_en === 1'b1) begin
            if (first == 0) first = i;
            else if (i - prev != 4) gap_err++;
            prev = i;
         end
      end
      run_mode = 1'b0;
      n_cmp++; if (en_seen - start !== 25) begin n_err++; $display("FAIL run_pulses: got %0d want 25", en_seen - start); end
      n_cmp++; if (first !== 5) begin n_err++; $display("FAIL run_first: got %0d want 5", first); end
      n_cmp++; if (gap_err !== 0) begin n_err++; $display("FAIL run_spacing: got %0d bad gaps want 0", gap_err); end
      repeat (10) tick;
      n_cmp++; if (en_seen - start !== 25) begin n_err++; $display("FAIL stop_extra_pulse: got %0d want 25", en_seen - start); end
      n_cmp++; if (state !== 2'd0) begin n_err++; $display("FAIL stop_state: got %0d want 0", state); end
      n_cmp++; if (cycle_cnt !== 16'd26) begin n_err++; $display("FAIL stop_cycle_cnt: got %0d want 26", cycle_cnt); end
      step = 1'b0;
      repeat (25) tick;
   endtask

   task automatic test_reset_mid_run;
      run_mode = 1'b1;
      repeat (3) tick;  // RUN entered, divider now 2
      n_cmp++; if (state !== 2'd1 || cycle_cnt !== 16'd26) begin n_err++; $display("FAIL pre_rst: state %0d cnt %0d want 1 26", state, cycle_cnt); end
      reset_n = 1'b0;
      #1;
      n_cmp++; if (cpu_en !== 1'b0 || halted !== 1'b0) begin n_err++; $display("FAIL mid_rst_en_halt: en %b halted %b want 0 0", cpu_en, halted); end
      n_cmp++; if (state !== 2'd0) begin n_err++; $display("FAIL mid_rst_state: got %0d want 0", state); end
      n_cmp++; if (cycle_cnt !== 16'd0) begin n_err++; $display("FAIL mid_rst_cnt: got %0d want 0", cycle_cnt); end
      run_mode = 1'b0;
      tick;
      reset_n = 1'b1;
      tick; tick;
      n_cmp++; if (state !== 2'd0 || cycle_cnt !== 16'd0) begin n_err++; $display("FAIL after_rst: state %0d cnt %0d want 0 0", state, cycle_cnt); end
   endtask

`ifdef CPU_BREAKPOINT_EN
   task automatic test_breakpoint;
      int start, npul, halt_at, first;
      logic [31:0] pul_pc [8];
      logic [31:0] first_pc;
      pc = 32'd0; bp_addr = 32'h0000_0010; bp_valid = 1'b1;
      start = en_seen; npul = 0; halt_at = 0;
      run_mode = 1'b1;
      for (int i = 1; i <= 40; i++) begin
         tick;
         if (cpu_en === 1'b1 && npul < 8) begin pul_pc[npul] = last_pc; npul++; end
         if (halted === 1'b1 && halt_at == 0) halt_at = i;
      end
      n_cmp++; if (npul !== 4) begin n_err++; $display("FAIL bp_pulses: got %0d want 4", npul); end
      for (int k = 0; k < 4 && k < npul; k++) begin
         n_cmp++;
         if (pul_pc[k] !== 32'(4 * k)) begin n_err++; $display("FAIL bp_pulse_pc%0d: got %0h want %0h", k, pul_pc[k], 4 * k); end
      end
      n_cmp++; if (halt_at !== 21) begin n_err++; $display("FAIL bp_halt_time: got %0d want 21", halt_at); end
      n_cmp++; if (state !== 2'd2 || halted !== 1'b1) begin n_err++; $display("FAIL bp_halt_state: state %0d halted %b want 2 1", state, halted); end
      run_mode = 1'b0; repeat (3) tick;
      run_mode = 1'b1; repeat (3) tick;
      n_cmp++; if (state !== 2'd2 || en_seen - start !== 4) begin n_err++; $display("FAIL halt_ignores_mode: state %0d pulses %0d want 2 4", state, en_seen - start); end
      step = 1'b1; first = 0; first_pc = 32'hFFFF_FFFF;
      for (int i = 1; i <= 30; i++) begin
         tick;
         if (cpu_en === 1'b1 && first == 0) begin first = i; first_pc = last_pc; end
      end
      step = 1'b0;
      n_cmp++; if (first !== 24) begin n_err++; $display("FAIL resume_time: got %0d want 24", first); end
      n_cmp++; if (first_pc !== 32'h10) begin n_err++; $display("FAIL resume_pc: got %0h want 10", first_pc); end
      n_cmp++; if (state !== 2'd1) begin n_err++; $display("FAIL resume_state: got %0d want 1", state); end
      bp_addr = 32'h18;
      halt_at = 0;
      for (int i = 1; i <= 10; i++) begin
         tick;
         if (halted === 1'b1 && halt_at == 0) halt_at = i;
      end
      n_cmp++; if (halt_at !== 2 || en_seen - start !== 6) begin n_err++; $display("FAIL rehalt: at %0d pulses %0d want 2 6", halt_at, en_seen - start); end
   endtask

   task automatic test_halted_step;
      int start, first;
      run_mode = 1'b0;
      repeat (25) tick;
      n_cmp++; if (state !== 2'd2) begin n_err++; $display("FAIL hstep_pre_state: got %0d want 2", state); end
      start = en_seen; first = 0;
      step = 1'b1;
      for (int i = 1; i <= 30; i++) begin
         tick;
         if (cpu_en === 1'b1 && first == 0) first = i;
      end
      step = 1'b0;
      n_cmp++; if (en_seen - start !== 1 || first !== 20) begin n_err++; $display("FAIL hstep_pulse: count %0d at %0d want 1 at 20", en_seen - start, first); end
      n_cmp++; if (state !== 2'd0 || halted !== 1'b0) begin n_err++; $display("FAIL hstep_state: state %0d halted %b want 0 0", state, halted); end
      n_cmp++; if (cycle_cnt !== 16'd7) begin n_err++; $display("FAIL hstep_cycle_cnt: got %0d want 7", cycle_cnt); end
      repeat (25) tick;
      bp_valid = 1'b0;
   endtask
`else
   task automatic test_bp_ignored;
      int start;
      pc_inc = 1'b0; pc = 32'h40; bp_addr = 32'h40; bp_valid = 1'b1;
      start = en_seen;
      run_mode = 1'b1;
      repeat (20) tick;
      n_cmp++; if (en_seen - start !== 4) begin n_err++; $display("FAIL bpoff_pulses: got %0d want 4", en_seen - start); end
      n_cmp++; if (state !== 2'd1 || halted !== 1'b0) begin n_err++; $display("FAIL bpoff_state: state %0d halted %b want 1 0", state, halted); end
      run_mode = 1'b0;
      tick; tick;
      n_cmp++; if (state !== 2'd0 || cycle_cnt !== 16'd4) begin n_err++; $display("FAIL bpoff_stop: state %0d cnt %0d want 0 4", state, cycle_cnt); end
      bp_valid = 1'b0; pc_inc = 1'b1;
   endtask
`endif

   task automatic test_counter_wrap;
      int pulses;
      pulses = 0;
      run_mode_w = 1'b1;
      for (int i = 1; i <= 65536; i++) begin
         @(posedge clk);
         #1;
         if (cpu_en_w === 1'b1) pulses++;
      end
      n_cmp++; if (pulses !== 65535) begin n_err++; $display("FAIL wrap_pulses: got %0d want 65535", pulses); end
      n_cmp++; if (cycle_cnt_w !== 16'hFFFF) begin n_err++; $display("FAIL wrap_pre: got %0h want ffff", cycle_cnt_w); end
      @(posedge clk);
      #1;
      n_cmp++; if (cycle_cnt_w !== 16'h0000 || cpu_en_w !== 1'b1) begin n_err++; $display("FAIL wrap_post: cnt %0h en %b want 0 1", cycle_cnt_w, cpu_en_w); end
      run_mode_w = 1'b0;
   endtask

   initial begin
      test_reset();
      test_debounce();
      test_run_pacing();
      test_reset_mid_run();
`ifdef CPU_BREAKPOINT_EN
      test_breakpoint();
      test_halted_step();
`else
      test_bp_ignored();
`endif
      test_counter_wrap();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
